// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the transmitter and its helpers.
//   spi_state_e : frame sequencer states (IDLE, LEAD, SHIFT, TRAIL, GAP)
//   SS_ACTIVE_* : slave-select polarity selectors
//   CPOL* / CPHA*: serial clock polarity / phase selectors
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam int SS_ACTIVE_LOW  = 0;
  localparam int SS_ACTIVE_HIGH = 1;
  localparam int CPOL0          = 0;
  localparam int CPOL1          = 1;
  localparam int CPHA0          = 0;
  localparam int CPHA1          = 1;

endpackage

// File: rtl/spi_transmitter_if.sv
// Bus bundle for spi_transmitter.
//   Parallel side : start, data (to transmitter); ready, complete (from it)
//   Serial side   : ss, sclk, sdo (from transmitter)
//   Debug         : state (current sequencer state)
//
// Handshake: a word is accepted on a rising clock edge where start=1 and
// ready=1; data is sampled on that same edge. start while ready=0 is
// dropped (no queueing). complete pulses for one cycle when a frame ends.
interface spi_transmitter_if
  import spi_pkg::*;
#(
  parameter int bitcount = 16
) ();

  logic                start;
  logic [bitcount-1:0] data;
  logic                ready;
  logic                complete;
  logic                ss;
  logic                sclk;
  logic                sdo;
  spi_state_e          state;

  // master: the side issuing words; slave: the transmitter itself
  modport master (
    output start, data,
    input  ready, complete, ss, sclk, sdo, state
  );

  modport slave (
    input  start, data,
    output ready, complete, ss, sclk, sdo, state
  );

endinterface

// File: rtl/spi_sclk_generator.sv
// Timing core for the SPI transmitter.
// Ports:
//   clock       : system clock
//   clear       : synchronous clear of both counters
//   enable      : advance the half-period counter
//   period_end  : last system cycle of the current half-period
//   edge_strobe : sclk must toggle on the coming clock edge
//   leading     : the strobed edge is a leading (odd-numbered) edge
//   last_edge   : the strobed edge is the final one of the frame
//   shift_done  : half-period after the final edge has elapsed
//
// The strobe is issued one cycle ahead so that the registered sclk
// toggles exactly at the start of each half-period.
module spi_sclk_generator #(
  parameter int bitcount      = 16,
  parameter int clock_divider = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  output logic period_end,
  output logic edge_strobe,
  output logic leading,
  output logic last_edge,
  output logic shift_done
);

  localparam int TW = $clog2(clock_divider) + 1;
  localparam int EW = $clog2(2 * bitcount) + 1;
  localparam logic [TW-1:0] TICK_MAX   = TW'(clock_divider - 1);
  localparam logic [EW-1:0] EDGE_TOTAL = EW'(2 * bitcount);
  localparam logic [EW-1:0] EDGE_LAST  = EW'(2 * bitcount - 1);

  logic [TW-1:0] tick_q;
  logic [EW-1:0] edge_cnt_q;

  // The edge counter saturates at EDGE_TOTAL, which also blocks further
  // strobes while the sequencer runs through TRAIL and GAP.
  always_comb begin
    period_end  = enable && (tick_q == TICK_MAX);
    edge_strobe = period_end && (edge_cnt_q != EDGE_TOTAL);
    leading     = ~edge_cnt_q[0];
    last_edge   = edge_strobe && (edge_cnt_q == EDGE_LAST);
    shift_done  = period_end && (edge_cnt_q == EDGE_TOTAL);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      tick_q     <= '0;
      edge_cnt_q <= '0;
    end else if (enable) begin
      tick_q <= period_end ? '0 : tick_q + 1'b1;
      if (edge_strobe) begin
        edge_cnt_q <= edge_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_transmitter.sv
// SPI master-side transmitter. Serialises a parallel word onto sdo and
// generates ss and sclk from the system clock.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : spi_transmitter_if slave modport
//           (start/data in, ready/complete/ss/sclk/sdo/state out)
// Frame: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE. LEAD, TRAIL and
// GAP each last clock_divider cycles; SHIFT carries 2*bitcount sclk edges.
// All outputs are registered.
module spi_transmitter
  import spi_pkg::*;
#(
  parameter int bitcount      = 16,
  parameter int ss_polarity   = 0,
  parameter int sclk_polarity = 1,
  parameter int sclk_phase    = 1,
  parameter int msb_first     = 1,
  parameter int clock_divider = 4
) (
  input  logic             clock,
  input  logic             reset,
  spi_transmitter_if.slave bus
);

  localparam logic SS_ON     = (ss_polarity == SS_ACTIVE_HIGH) ? 1'b1 : 1'b0;
  localparam logic SS_OFF    = ~SS_ON;
  localparam logic SCLK_IDLE = (sclk_polarity == CPOL1) ? 1'b1 : 1'b0;
  localparam logic CPHA_ON   = (sclk_phase == CPHA1) ? 1'b1 : 1'b0;

  // sdo is always taken from a fixed end of the shift register; the
  // register shifts toward that end.
  function automatic logic out_bit(input logic [bitcount-1:0] w);
    return (msb_first != 0) ? w[bitcount-1] : w[0];
  endfunction

  function automatic logic [bitcount-1:0] shifted(input logic [bitcount-1:0] w);
    return (msb_first != 0) ? {w[bitcount-2:0], 1'b0} : {1'b0, w[bitcount-1:1]};
  endfunction

  spi_state_e          state_q, state_d;
  logic [bitcount-1:0] sreg_q, sreg_d;
  logic                ss_q, ss_d;
  logic                sclk_q, sclk_d;
  logic                sdo_q, sdo_d;
  logic                ready_q, ready_d;
  logic                complete_q, complete_d;

  logic period_end, edge_strobe, leading, last_edge, shift_done;

  spi_sclk_generator #(
    .bitcount      (bitcount),
    .clock_divider (clock_divider)
  ) u_sclk_gen (
    .clock       (clock),
    .clear       (reset || (state_q == IDLE)),
    .enable      (state_q != IDLE),
    .period_end  (period_end),
    .edge_strobe (edge_strobe),
    .leading     (leading),
    .last_edge   (last_edge),
    .shift_done  (shift_done)
  );

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    ss_d       = ss_q;
    sclk_d     = sclk_q;
    sdo_d      = sdo_q;
    ready_d    = ready_q;
    complete_d = 1'b0;

    // Strobes only occur in LEAD (first edge) and SHIFT. With CPHA=1 bits
    // launch on leading edges; with CPHA=0 bit 0 launches at ss assertion
    // and the rest on trailing edges, and the final edge leaves sdo alone.
    if (edge_strobe) begin
      sclk_d = ~sclk_q;
      if ((CPHA_ON && leading) || (!CPHA_ON && !leading && !last_edge)) begin
        sdo_d  = out_bit(sreg_q);
        sreg_d = shifted(sreg_q);
      end
    end

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.start) begin
          state_d = LEAD;
          ready_d = 1'b0;
          ss_d    = SS_ON;
          sreg_d  = bus.data;
          if (!CPHA_ON) begin
            sdo_d  = out_bit(bus.data);
            sreg_d = shifted(bus.data);
          end
        end
      end
      LEAD: begin
        if (period_end) state_d = SHIFT;
      end
      SHIFT: begin
        if (shift_done) state_d = TRAIL;
      end
      TRAIL: begin
        if (period_end) begin
          state_d    = GAP;
          ss_d       = SS_OFF;
          sdo_d      = 1'b0;
          complete_d = 1'b1;
        end
      end
      GAP: begin
        if (period_end) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      ss_q       <= SS_OFF;
      sclk_q     <= SCLK_IDLE;
      sdo_q      <= 1'b0;
      ready_q    <= 1'b1;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      ss_q       <= ss_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      ready_q    <= ready_d;
      complete_q <= complete_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.complete = complete_q;
  assign bus.ss       = ss_q;
  assign bus.sclk     = sclk_q;
  assign bus.sdo      = sdo_q;
  assign bus.state    = state_q;

endmodule
